motor_step_gen: RTL
===================

# motor_step_gen

Stepper pulse generator sitting directly downstream of the SOPC's 16-bit motor PIO exports (motorx/motory/motora/motorb); one instance per axis. Decodes a static command word written by the Nios software into a counted burst of STEP pulses with a DIR line, fixed period and pulse width. Reports busy/done and a running signed position back to software through an input PIO.

## Interface
- PERIOD, 50000: clock cycles per step (1 kHz at 50 MHz); must be > PULSE_W.
- PULSE_W, 100: STEP high time in cycles; ≥ 1.
- DIR_SETUP, 50: cycles DIR is stable before the first STEP rise; ≥ 1.
- clk_clk  input  1  system clock, all logic on rising edge.
- reset_reset  input  1  asynchronous, active-high reset.
- cmd  input  16  motor PIO word: [15] GO, [14] DIR, [13:0] STEPS.
- step  output  1  step pulse to driver.
- dir  output  1  direction to driver (1 = positive).
- busy  output  1  high while a move is in progress.
- done  output  1  one-cycle pulse on normal move completion.
- aborted  output  1  sticky: last move ended by GO falling; cleared at next start.
- pos  output  16  signed step position, two's complement.

## Operation
- States: IDLE, SETUP, HIGH, LOW.
- IDLE: step=0, busy=0. Start event = GO rising edge (registered previous GO 0, current 1).
  - Start with STEPS≠0: latch DIR into dir, load remaining=STEPS, clear aborted, timer=DIR_SETUP → SETUP.
  - Start with STEPS=0: done pulses one cycle, stay IDLE, dir unchanged.
- SETUP: step=0; after DIR_SETUP cycles → HIGH, timer=PULSE_W.
- HIGH: step=1 for PULSE_W cycles → LOW, timer=PERIOD−PULSE_W; on entry to LOW: remaining−1, pos±1 (+ if dir=1, − if dir=0).
- LOW: step=0; at timer expiry: remaining=0 → IDLE with done; else → HIGH.
- Abort: GO sampled 0 while busy. In SETUP → IDLE immediately, no pulse. In HIGH → finish pulse (no truncated pulses), count it, then IDLE. In LOW → IDLE immediately. aborted=1, done not asserted.
- cmd changes other than GO during a move are ignored; DIR/STEPS are latched only at start.
- Re-trigger requires GO low then high; GO held high after completion does not restart.
- pos wraps modulo 2^16 (32767+1 → −32768); never reset except by reset_reset.

## Timing
- Reset values: step=0, dir=0, busy=0, done=0, aborted=0, pos=0, state IDLE, timer/remaining 0.
- All outputs registered. GO rising sampled at edge N: busy=1 and dir valid after edge N+1; step rises after edge N+1+DIR_SETUP.
- step period exactly PERIOD cycles; high exactly PULSE_W cycles.
- Last step fall → PERIOD−PULSE_W cycles later busy falls and done=1 for that same single cycle.
- pos updates on the edge step falls.
- Abort latency: GO low sampled at edge M in LOW/SETUP → busy=0 after M+1; in HIGH → after pulse end.
- Reset mid-move: all outputs immediately to reset values (step drops asynchronously).

## Structure
- Package motor_pkg: state enum, cmd field constants (GO_BIT=15, DIR_BIT=14, STEPS_MSB=13), width constant for pos/remaining.
- One sub-module natural: phase_timer — loadable down-counter with expiry flag, width $clog2(max(PERIOD, DIR_SETUP)+1).

## Test plan
Bench parameters PERIOD=10, PULSE_W=3, DIR_SETUP=2.
- Reset then cmd=0xC005 (GO, DIR=1, 5 steps) → 5 pulses, 3 high/7 low, first rise 3 cycles after GO edge, done one cycle, pos=5.
- Then cmd=0x0000, cmd=0x8003 → dir=0 set before first rise, 3 pulses, pos=2.
- cmd=0x8000 (STEPS=0) → done one cycle, busy never asserted, no step, pos unchanged.
- cmd=0xC00A, drop GO during 4th HIGH phase → 4th pulse completes full 3 cycles, busy falls, aborted=1, done=0, pos +4.
- Preload pos=32766 via moves, cmd=0xC003 → pos 32767, −32768, −32767.
- Assert reset_reset mid-HIGH → step=0 same cycle, all outputs at reset values; GO held high after release → no move until GO toggles.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the stepper pulse generator: FSM states,
// command-word field positions and position/step-count widths.
package motor_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW
   } state_e;

   localparam int CMD_W     = 16;
   localparam int GO_BIT    = 15;
   localparam int DIR_BIT   = 14;
   localparam int STEPS_MSB = 13;
   localparam int REM_W     = STEPS_MSB + 1;
   localparam int POS_W     = 16;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter: after a load of N it reports expiry during the Nth
// cycle, so the owning state lasts exactly N cycles.
module phase_timer #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Parked at zero when idle so it never reports a stale expiry.
   assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/motor_step_gen.sv
// Per-axis stepper pulse generator: turns a GO/DIR/STEPS command word into a
// counted burst of fixed-period STEP pulses and tracks a signed position.
module motor_step_gen
   import motor_pkg::*;
#(
   parameter int PERIOD    = 50000,
   parameter int PULSE_W   = 100,
   parameter int DIR_SETUP = 50
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset,
   input  logic [CMD_W-1:0]        cmd,
   output logic                    step,
   output logic                    dir,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic signed [POS_W-1:0] pos
);

   localparam int TW = $clog2(max2(PERIOD, DIR_SETUP) + 1);
   localparam logic [TW-1:0] DS_CYC  = TW'(DIR_SETUP);
   localparam logic [TW-1:0] PW_CYC  = TW'(PULSE_W);
   localparam logic [TW-1:0] LOW_CYC = TW'(PERIOD - PULSE_W);
   localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

   state_e                    state_q;
   logic                      step_q;
   logic                      dir_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      aborted_q;
   logic                      abort_pend_q;
   logic                      go_s_q;
   logic                      go_prev_q;
   logic                      dir_s_q;
   logic [REM_W-1:0]          steps_s_q;
   logic [REM_W-1:0]          rem_q;
   logic signed [POS_W-1:0]   pos_q;

   logic                      start;
   logic                      tmr_load;
   logic [TW-1:0]             tmr_val;
   logic                      tmr_exp;

   // The command word is sampled once per cycle; start and abort decisions
   // act on this sample, which puts busy one edge after the GO rise is seen.
   always_ff @(posedge clk_clk) begin
      dir_s_q   <= cmd[DIR_BIT];
      steps_s_q <= cmd[STEPS_MSB:0];
   end

   assign start = go_s_q & ~go_prev_q;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         S_IDLE: begin
            if (start && (steps_s_q != '0)) begin
               tmr_load = 1'b1;
               tmr_val  = DS_CYC;
            end
         end
         S_SETUP: begin
            if (go_s_q && tmr_exp) begin
               tmr_load = 1'b1;
               tmr_val  = PW_CYC;
            end
         end
         S_HIGH: begin
            if (tmr_exp && go_s_q && !abort_pend_q) begin
               tmr_load = 1'b1;
               tmr_val  = LOW_CYC;
            end
         end
         S_LOW: begin
            if (go_s_q && tmr_exp && (rem_q != '0)) begin
               tmr_load = 1'b1;
               tmr_val  = PW_CYC;
            end
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   phase_timer #(
      .W (TW)
   ) u_timer (
      .clk_i      (clk_clk),
      .rst_i      (reset_reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_exp)
   );

   // GO samples reset high so a GO held across reset release is not a start.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q      <= S_IDLE;
         step_q       <= 1'b0;
         dir_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         go_s_q       <= 1'b1;
         go_prev_q    <= 1'b1;
         rem_q        <= '0;
         pos_q        <= '0;
      end else begin
         go_s_q    <= cmd[GO_BIT];
         go_prev_q <= go_s_q;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               step_q       <= 1'b0;
               busy_q       <= 1'b0;
               abort_pend_q <= 1'b0;
               if (start) begin
                  if (steps_s_q == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     dir_q     <= dir_s_q;
                     rem_q     <= steps_s_q;
                     aborted_q <= 1'b0;
                     busy_q    <= 1'b1;
                     state_q   <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               if (!go_s_q) begin
                  busy_q    <= 1'b0;
                  aborted_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else if (tmr_exp) begin
                  step_q  <= 1'b1;
                  state_q <= S_HIGH;
               end
            end
            S_HIGH: begin
               // A GO drop mid-pulse is remembered so the pulse still completes.
               if (!go_s_q) begin
                  abort_pend_q <= 1'b1;
               end
               if (tmr_exp) begin
                  step_q <= 1'b0;
                  rem_q  <= rem_q - REM_W'(1);
                  pos_q  <= dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                  if (!go_s_q || abort_pend_q) begin
                     busy_q       <= 1'b0;
                     aborted_q    <= 1'b1;
                     abort_pend_q <= 1'b0;
                     state_q      <= S_IDLE;
                  end else begin
                     state_q <= S_LOW;
                  end
               end
            end
            S_LOW: begin
               if (!go_s_q) begin
                  busy_q    <= 1'b0;
                  aborted_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else if (tmr_exp) begin
                  if (rem_q == '0) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     step_q  <= 1'b1;
                     state_q <= S_HIGH;
                  end
               end
            end
            default: begin
               step_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign step    = step_q;
   assign dir     = dir_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign pos     = pos_q;

endmodule
